commit_trace_buffer: RTL
========================

Name: commit_trace_buffer

Overview:
- Synthesizable retirement-trace recorder for the sequential RISC-V core and its successors.
- Captures one entry per retired instruction (PC, instruction, writeback) into a circular buffer.
- Supports arm, PC-match trigger with post-trigger depth, and wrap or stop-on-full policy.
- Drains captured entries over a valid/ready port, so benches and on-chip debug stop depending on hierarchical $display probing.

Parameters:
- XLEN, 64, data/PC width.
- DEPTH, 16, buffer entries; power of two, >=2.
- POST_TRIG, 4, entries recorded after the trigger entry; 0..DEPTH-1.
- TS_W, 32, timestamp width (only used with TRACE_TIMESTAMP_EN).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- arm  in  1  pulse: clear buffer and flags, enter CAPTURE.
- stop  in  1  pulse: CAPTURE/POST -> DONE.
- mode_wrap  in  1  1 = overwrite oldest when full; 0 = drop new when full.
- trig_en  in  1  enable PC-match trigger.
- trig_pc  in  XLEN  trigger PC.
- commit_valid  in  1  an instruction retires this cycle.
- commit_pc  in  XLEN  PC of the retiring instruction.
- commit_instr  in  32  instruction word.
- commit_reg_write  in  1  rd written.
- commit_rd  in  5  destination register.
- commit_wdata  in  XLEN  writeback value.
- out_valid  out  1  head entry available.
- out_ready  in  1  consumer accepts the head entry.
- out_pc  out  XLEN  head entry PC.
- out_instr  out  32  head entry instruction.
- out_reg_write  out  1  head entry rd-written flag.
- out_rd  out  5  head entry rd.
- out_wdata  out  XLEN  head entry writeback value.
- count  out  $clog2(DEPTH)+1  entries held.
- overflow  out  1  sticky: at least one commit lost or overwritten.
- triggered  out  1  sticky: trigger fired.
- done  out  1  FSM in DONE.

Behaviour:
- Reset (async, reset_n=0):
  - FSM=IDLE; write pointer, read pointer and count = 0.
  - overflow = triggered = done = 0; out_valid = 0.
  - out_* data outputs = 0; storage contents are don't-care.
- FSM states:
  - IDLE: no capture.
  - CAPTURE: every commit_valid cycle records one entry.
  - POST: counting post-trigger entries.
  - DONE: no capture; done=1.
- Arm and stop:
  - arm in any state (highest priority): pointers, count and sticky flags clear; FSM=CAPTURE next cycle. A commit in the arm cycle is not recorded.
  - stop in CAPTURE or POST: FSM=DONE; a commit in the same cycle is still recorded. stop in IDLE or DONE is ignored.
- Trigger:
  - Fires in CAPTURE when trig_en && commit_valid && commit_pc==trig_pc. The matching entry is recorded and triggered=1.
  - POST_TRIG=0 -> DONE; otherwise -> POST with remaining=POST_TRIG.
  - The trigger is evaluated only in CAPTURE; matches in POST do not retrigger.
- POST: each commit_valid decrements remaining, whether the entry is stored or dropped. When remaining reaches 0 (transition 1->0), FSM=DONE the next cycle.
- Full, mode_wrap=1: new entry overwrites the oldest; read pointer advances; count stays DEPTH; overflow=1.
- Full, mode_wrap=0: new entry dropped; count unchanged; overflow=1; trigger and POST counting still apply.
- Sampling: mode_wrap is sampled per commit, so changing it mid-capture takes effect on the next commit.
- Readout:
  - out_valid = (count!=0) && state in {IDLE, DONE} && !arm.
  - out_* present the head entry combinationally from storage.
  - A pop occurs when out_valid && out_ready: read pointer +1, count -1.
  - No reads in CAPTURE or POST, so push and pop never coincide.
- Pointers are $clog2(DEPTH) bits and wrap naturally; count saturates only by construction (0..DEPTH).
- Latency: an entry committed in cycle N is readable from cycle N+1, once the FSM is in DONE.
- Reset mid-operation: immediate return to reset values; captured data is lost.

Optional Feature:
- Macro: TRACE_TIMESTAMP_EN.
- Defined:
  - Adds a free-running TS_W-bit cycle counter, reset to 0, incrementing every clk and wrapping modulo 2^TS_W.
  - The counter value is stored with each entry.
  - Adds output port out_ts [TS_W] for the head entry.
  - arm does not clear the counter.
- Undefined: no counter, no out_ts port, no storage cost.

Test Plan:
- Basic capture:
  - Stimulus: arm; 3 commits (pc=0x0,0x4,0x8, instr=0x00A00093/0x00B00113/0x002081B3, rd=1/2/3, wdata=10/11/21); stop; out_ready=1.
  - Response: count=3 before draining, done=1; entries read in order; count returns to 0; overflow=0.
- Trigger with post-depth:
  - Stimulus: POST_TRIG=4, trig_en=1, trig_pc=0x20; commits at pc 0x0..0x40, step 4.
  - Response: triggered=1 at pc 0x20; DONE after pc 0x30; count=13; last entry pc=0x30.
- Wrap overflow:
  - Stimulus: DEPTH=16, mode_wrap=1; 20 commits pc=0..0x4C; stop.
  - Response: count=16, overflow=1; first read pc=0x10, last pc=0x4C.
- Drop overflow:
  - Stimulus: mode_wrap=0, same stimulus.
  - Response: count=16, overflow=1; first read pc=0x0, last pc=0x3C.
- Arm priority:
  - Stimulus: in DONE with 5 entries, assert arm with out_ready=1 and commit_valid=1.
  - Response: out_valid=0 that cycle; count=0 and CAPTURE next cycle; arm-cycle commit not stored.
- Async reset mid-capture:
  - Stimulus: drop reset_n between clock edges during POST.
  - Response: done, triggered, overflow, count and out_valid = 0 immediately; FSM=IDLE.
  - With TRACE_TIMESTAMP_EN: entries from back-to-back commits show out_ts differing by 1.

Source files
------------

// File: rtl/commit_trace_buffer.sv
// Retirement-trace recorder: captures one entry per retired instruction into a circular buffer
// and drains it over a valid/ready port. Optional macro TRACE_TIMESTAMP_EN adds per-entry timestamps.
module commit_trace_buffer #(
  parameter int XLEN      = 64,
  parameter int DEPTH     = 16,
  parameter int POST_TRIG = 4,
  parameter int TS_W      = 32
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     arm,
  input  logic                     stop,
  input  logic                     mode_wrap,
  input  logic                     trig_en,
  input  logic [XLEN-1:0]          trig_pc,
  input  logic                     commit_valid,
  input  logic [XLEN-1:0]          commit_pc,
  input  logic [31:0]              commit_instr,
  input  logic                     commit_reg_write,
  input  logic [4:0]               commit_rd,
  input  logic [XLEN-1:0]          commit_wdata,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [XLEN-1:0]          out_pc,
  output logic [31:0]              out_instr,
  output logic                     out_reg_write,
  output logic [4:0]               out_rd,
  output logic [XLEN-1:0]          out_wdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     triggered,
  output logic                     done,
`ifdef TRACE_TIMESTAMP_EN
  output logic [TS_W-1:0]          out_ts,
`endif
  output logic [1:0]               state_dbg
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CAPTURE = 2'd1,
    S_POST    = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  state_t state, next_state;

  logic [AW-1:0] wr_ptr, rd_ptr, remaining;

  logic [XLEN-1:0] mem_pc    [DEPTH];
  logic [31:0]     mem_instr [DEPTH];
  logic            mem_rw    [DEPTH];
  logic [4:0]      mem_rd    [DEPTH];
  logic [XLEN-1:0] mem_wdata [DEPTH];

  logic in_cap, cap_commit, full, do_write, trig_hit, post_last, pop, head_ok;

  assign in_cap     = (state == S_CAPTURE) || (state == S_POST);
  assign cap_commit = in_cap && commit_valid && !arm;
  assign full       = (count == CW'(DEPTH));
  assign do_write   = cap_commit && (!full || mode_wrap);
  assign trig_hit   = (state == S_CAPTURE) && trig_en && commit_valid &&
                      (commit_pc == trig_pc) && !arm;
  assign post_last  = (state == S_POST) && commit_valid && (remaining == AW'(1));
  assign head_ok    = (count != '0);
  assign out_valid  = head_ok && ((state == S_IDLE) || (state == S_DONE)) && !arm;
  assign pop        = out_valid && out_ready;
  assign done       = (state == S_DONE);
  assign state_dbg  = state;

  // Head data is gated by occupancy so the outputs read zero out of reset.
  assign out_pc        = head_ok ? mem_pc[rd_ptr]    : '0;
  assign out_instr     = head_ok ? mem_instr[rd_ptr] : '0;
  assign out_reg_write = head_ok ? mem_rw[rd_ptr]    : 1'b0;
  assign out_rd        = head_ok ? mem_rd[rd_ptr]    : '0;
  assign out_wdata     = head_ok ? mem_wdata[rd_ptr] : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= next_state;
  end

  always_comb begin
    next_state = state;
    if (arm) begin
      next_state = S_CAPTURE;
    end else begin
      case (state)
        S_CAPTURE: begin
          if (stop)          next_state = S_DONE;
          else if (trig_hit) next_state = (POST_TRIG == 0) ? S_DONE : S_POST;
        end
        S_POST: if (stop || post_last) next_state = S_DONE;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      remaining <= '0;
      overflow  <= 1'b0;
      triggered <= 1'b0;
    end else if (arm) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      remaining <= '0;
      overflow  <= 1'b0;
      triggered <= 1'b0;
    end else begin
      if (cap_commit) begin
        if (!full) begin
          wr_ptr <= wr_ptr + 1'b1;
          count  <= count + 1'b1;
        end else begin
          overflow <= 1'b1;
          // Wrap mode: the new entry replaces the oldest, so both pointers advance.
          if (mode_wrap) begin
            wr_ptr <= wr_ptr + 1'b1;
            rd_ptr <= rd_ptr + 1'b1;
          end
        end
      end else if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
        count  <= count - 1'b1;
      end
      if (trig_hit) begin
        triggered <= 1'b1;
        remaining <= AW'(POST_TRIG);
      end else if ((state == S_POST) && commit_valid && (remaining != '0)) begin
        remaining <= remaining - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (do_write) begin
      mem_pc[wr_ptr]    <= commit_pc;
      mem_instr[wr_ptr] <= commit_instr;
      mem_rw[wr_ptr]    <= commit_reg_write;
      mem_rd[wr_ptr]    <= commit_rd;
      mem_wdata[wr_ptr] <= commit_wdata;
    end
  end

`ifdef TRACE_TIMESTAMP_EN
  logic [TS_W-1:0] ts_cnt;
  logic [TS_W-1:0] mem_ts [DEPTH];

  // Free-running; arm deliberately leaves it alone so timestamps stay comparable across captures.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) ts_cnt <= '0;
    else          ts_cnt <= ts_cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (do_write) mem_ts[wr_ptr] <= ts_cnt;
  end

  assign out_ts = head_ok ? mem_ts[rd_ptr] : '0;
`endif

endmodule
